// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I memory access stage with held dmem handshake and MEM/WB pipeline register
module mem_wb_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic                   ex_mem_read,
    input  logic                   ex_mem_write,
    input  logic [2:0]             ex_funct3,
    input  logic [XLEN-1:0]        ex_addr,
    input  logic [XLEN-1:0]        ex_rs2,
    input  logic [XLEN-1:0]        ex_alu,
    input  logic                   ex_br_en,
    input  logic [XLEN-1:0]        ex_u_imm,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_load_regfile,
    input  logic [2:0]             ex_wb_sel,
    output logic [XLEN-1:0]        dmem_addr,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [3:0]             dmem_wmask,
    output logic [XLEN-1:0]        dmem_wdata,
    input  logic [XLEN-1:0]        dmem_rdata,
    input  logic                   dmem_resp,
    output logic                   stall,
    output logic                   misaligned,
    output logic                   wb_valid,
    output logic                   wb_load_regfile,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic [XLEN-1:0]        wb_pc,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic is_mem, is_h, is_w, bad_st, mis, access;
    logic [XLEN-1:0] shifted, load_val, wb_data_d;
    logic [XLEN-1:0] wb_data_q, wb_pc_q;
    logic [4:0] wb_rd_q;
    logic wb_valid_q, wb_load_regfile_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    // Decode access legality, drive the memory port and build the write-back value
    always_comb begin
        is_mem     = ex_valid & (ex_mem_read | ex_mem_write);
        is_h       = ex_funct3[1:0] == 2'b01;
        is_w       = ex_funct3[1:0] == 2'b10;
        bad_st     = ex_mem_write & (ex_funct3[2] | (&ex_funct3[1:0]));
        mis        = is_mem & ((is_h & ex_addr[0]) | (is_w & (|ex_addr[1:0])) | bad_st);
        access     = is_mem & ~mis;
        stall      = access & ~dmem_resp;
        misaligned = mis;
        dmem_addr  = {ex_addr[XLEN-1:2], 2'b00};
        dmem_read  = access & ex_mem_read;
        dmem_write = access & ex_mem_write;
        dmem_wmask = ~dmem_write ? 4'h0 : is_w ? 4'hF : ((is_h ? 4'b0011 : 4'b0001) << ex_addr[1:0]);
        dmem_wdata = ex_rs2 << {ex_addr[1:0], 3'b000};
        shifted    = dmem_rdata >> {ex_addr[1:0], 3'b000};
        load_val   = ex_funct3[1:0] == 2'b00 ? {{(XLEN-8){~ex_funct3[2] & shifted[7]}}, shifted[7:0]} :
                     is_h ? {{(XLEN-16){~ex_funct3[2] & shifted[15]}}, shifted[15:0]} : dmem_rdata;
        wb_data_d  = ex_wb_sel == 3'd1 ? {{(XLEN-1){1'b0}}, ex_br_en} :
                     ex_wb_sel == 3'd2 ? ex_u_imm :
                     ex_wb_sel == 3'd3 ? load_val :
                     ex_wb_sel == 3'd4 ? ex_pc + XLEN'(4) : ex_alu;
        state_d    = state_q == IDLE ? ((access & ~dmem_resp) ? WAIT : IDLE) : (dmem_resp ? IDLE : WAIT);
    end
    // Handshake state, MEM/WB register (bubble while stalled) and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            wb_valid_q        <= 1'b0;
            wb_load_regfile_q <= 1'b0;
            wb_rd_q           <= '0;
            wb_data_q         <= '0;
            wb_pc_q           <= '0;
            stall_cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (stall) begin
                wb_valid_q        <= 1'b0;
                wb_load_regfile_q <= 1'b0;
                if (~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end else begin
                wb_valid_q        <= ex_valid;
                wb_load_regfile_q <= ex_valid & ex_load_regfile & ~mis;
                wb_rd_q           <= ex_rd;
                wb_data_q         <= wb_data_d;
                wb_pc_q           <= ex_pc;
            end
        end
    end
    assign wb_valid        = wb_valid_q;
    assign wb_load_regfile = wb_load_regfile_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign wb_pc           = wb_pc_q;
    assign stall_cycles    = stall_cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of load/store handshake, alignment, write-back mux and reset
module tb_mem_wb_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic ex_valid = 0, ex_mem_read = 0, ex_mem_write = 0, ex_br_en = 0, ex_load_regfile = 0;
    logic [2:0] ex_funct3 = 0, ex_wb_sel = 0;
    logic [31:0] ex_addr = 0, ex_rs2 = 0, ex_alu = 0, ex_u_imm = 0, ex_pc = 0;
    logic [4:0] ex_rd = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0, wb_data, wb_pc, stall_cycles;
    logic dmem_read, dmem_write, dmem_resp = 0, stall, misaligned, wb_valid, wb_load_regfile;
    logic [3:0] dmem_wmask;
    logic [4:0] wb_rd;
    int errors = 0, checks = 0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_rs2(ex_rs2), .ex_alu(ex_alu), .ex_br_en(ex_br_en),
        .ex_u_imm(ex_u_imm), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_load_regfile(ex_load_regfile),
        .ex_wb_sel(ex_wb_sel), .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .stall(stall), .misaligned(misaligned), .wb_valid(wb_valid), .wb_load_regfile(wb_load_regfile),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] sel,
                         input logic lr, input logic [4:0] rd, input logic [31:0] pc);
        ex_valid = v; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3; ex_addr = addr;
        ex_rs2 = rs2; ex_wb_sel = sel; ex_load_regfile = lr; ex_rd = rd; ex_pc = pc;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_dmem_read", {31'b0, dmem_read}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 0;
        ex_alu = 32'h0000_0077; ex_u_imm = 32'h1234_5000; ex_br_en = 1'b1;

        // 1: LW with response after 3 waiting cycles
        instr(1, 1, 0, 3'b010, 32'h100, 0, 3'd3, 1, 5'd5, 32'h10);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_dmem_read", {31'b0, dmem_read}, 32'd1);
            chk("lw_stall", {31'b0, stall}, 32'd1);
            chk("lw_dmem_addr", dmem_addr, 32'h100);
            tick();
            chk("lw_bubble", {31'b0, wb_valid}, 32'd0);
        end
        dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_resp_stall", {31'b0, stall}, 32'd0);
        chk("lw_resp_wmask", {28'b0, dmem_wmask}, 32'd0);
        tick();
        chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("lw_wb_lr", {31'b0, wb_load_regfile}, 32'd1);
        chk("lw_wb_rd", {27'b0, wb_rd}, 32'd5);
        chk("lw_wb_pc", wb_pc, 32'h10);
        chk("lw_stall_cycles", stall_cycles, 32'd3);

        // 2: LB / LBU at 0x103 with same-cycle response
        instr(1, 1, 0, 3'b000, 32'h103, 0, 3'd3, 1, 5'd6, 32'h14);
        dmem_rdata = 32'h80FF_0000;
        #1;
        chk("lb_stall", {31'b0, stall}, 32'd0);
        chk("lb_dmem_addr", dmem_addr, 32'h100);
        tick();
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        instr(1, 1, 0, 3'b100, 32'h103, 0, 3'd3, 1, 5'd7, 32'h18);
        tick();
        chk("lbu_wb_data", wb_data, 32'h0000_0080);
        instr(1, 1, 0, 3'b001, 32'h102, 0, 3'd3, 1, 5'd7, 32'h1C);
        tick();
        chk("lh_wb_data", wb_data, 32'hFFFF_80FF);
        chk("lb_stall_cycles", stall_cycles, 32'd3);
        dmem_resp = 0;

        // 3: SH at 0x202, held write until response
        instr(1, 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 3'd0, 0, 5'd0, 32'h20);
        #1;
        chk("sh_write", {31'b0, dmem_write}, 32'd1);
        chk("sh_addr", dmem_addr, 32'h200);
        chk("sh_wmask", {28'b0, dmem_wmask}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_0000);
        chk("sh_stall", {31'b0, stall}, 32'd1);
        tick();
        chk("sh_write_held", {31'b0, dmem_write}, 32'd1);
        chk("sh_bubble", {31'b0, wb_valid}, 32'd0);
        dmem_resp = 1;
        #1;
        chk("sh_resp_stall", {31'b0, stall}, 32'd0);
        tick();
        dmem_resp = 0;
        chk("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sh_wb_lr", {31'b0, wb_load_regfile}, 32'd0);
        chk("sh_stall_cycles", stall_cycles, 32'd4);

        // SB at 0x201 lane check
        instr(1, 0, 1, 3'b000, 32'h201, 32'h0000_00EE, 3'd0, 0, 5'd0, 32'h24);
        #1;
        chk("sb_wmask", {28'b0, dmem_wmask}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h0000_EE00);

        // 4: misaligned LW
        instr(1, 1, 0, 3'b010, 32'h101, 0, 3'd3, 1, 5'd9, 32'h28);
        #1;
        chk("mis_read", {31'b0, dmem_read}, 32'd0);
        chk("mis_flag", {31'b0, misaligned}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("mis_wb_lr", {31'b0, wb_load_regfile}, 32'd0);
        instr(0, 1, 0, 3'b010, 32'h101, 0, 3'd3, 1, 5'd9, 32'h2C);
        #1;
        chk("mis_pulse_end", {31'b0, misaligned}, 32'd0);
        chk("bubble_no_read", {31'b0, dmem_read}, 32'd0);

        // 5: reset in WAIT of a load, then a late response
        instr(1, 1, 0, 3'b010, 32'h300, 0, 3'd3, 1, 5'd10, 32'h30);
        tick();
        chk("rstw_stall", {31'b0, stall}, 32'd1);
        rst = 1;
        instr(0, 0, 0, 3'b000, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0);
        tick();
        rst = 0;
        chk("rstw_read", {31'b0, dmem_read}, 32'd0);
        chk("rstw_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rstw_stall_cycles", stall_cycles, 32'd0);
        dmem_resp = 1; dmem_rdata = 32'h1111_2222;
        tick();
        dmem_resp = 0;
        chk("late_resp_valid", {31'b0, wb_valid}, 32'd0);
        chk("late_resp_lr", {31'b0, wb_load_regfile}, 32'd0);

        // 6: jal then lui back-to-back, then pc+4 wrap and br_en
        instr(1, 0, 0, 3'b000, 32'h0, 0, 3'd4, 1, 5'd1, 32'h40);
        #1;
        chk("jal_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("jal_wb_data", wb_data, 32'h44);
        chk("jal_wb_valid", {31'b0, wb_valid}, 32'd1);
        instr(1, 0, 0, 3'b000, 32'h0, 0, 3'd2, 1, 5'd2, 32'h44);
        tick();
        chk("lui_wb_data", wb_data, 32'h1234_5000);
        chk("lui_wb_rd", {27'b0, wb_rd}, 32'd2);
        chk("lui_wb_valid", {31'b0, wb_valid}, 32'd1);
        instr(1, 0, 0, 3'b000, 32'h0, 0, 3'd4, 1, 5'd3, 32'hFFFF_FFFC);
        tick();
        chk("pc4_wrap", wb_data, 32'h0);
        instr(1, 0, 0, 3'b000, 32'h0, 0, 3'd1, 1, 5'd4, 32'h50);
        tick();
        chk("br_en_wb", wb_data, 32'h1);
        instr(1, 0, 0, 3'b000, 32'h0, 0, 3'd7, 1, 5'd4, 32'h54);
        tick();
        chk("alu_default_wb", wb_data, 32'h77);
        chk("final_stall_cycles", stall_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
